griffin_affine_sched: RTL
=========================

GRIFFIN_AFFINE_SCHED -- requirements
Module: griffin_affine_sched

Interface
REQ-001 Parameters SHALL be, one per line:
- N_BITS, 254, field element width.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p.
- STATE_SIZE, 3, state elements per permutation.
- NUM_ROUNDS, 14, affine rounds applied per job (legal range 1..2^RC_ADDR_W).
- RC_ADDR_W, 4, round-constant address width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  scheduler can accept a job.
- in_state  in  N_BITS x STATE_SIZE  initial state.
- rc_addr  out  RC_ADDR_W  round-constant ROM address (round index).
- rc_data  in  N_BITS x STATE_SIZE  ROM data, valid one cycle after rc_addr.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_state  out  N_BITS x STATE_SIZE  final state.
- busy  out  1  high in any state other than IDLE.

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low on rst_n, clocked on clk.

Function
REQ-004 The FSM SHALL have four states: IDLE, FETCH, APPLY, DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; a job is accepted when in_valid&&in_ready, which captures in_state into state_reg, clears round counter, and moves to FETCH.
REQ-006 rc_addr SHALL equal the registered round counter in all states.
REQ-007 FETCH SHALL last exactly one cycle and then go to APPLY.
REQ-008 APPLY SHALL update state_reg[i] <= (state_reg[i] + rc_data[i] + S) mod p, where S = (sum of all state_reg elements) mod p.
REQ-009 In APPLY, if round == NUM_ROUNDS-1 the FSM SHALL go to DONE; otherwise it SHALL increment round and go to FETCH.
REQ-010 For a job accepted in cycle T, out_valid SHALL first be high in cycle T+2*NUM_ROUNDS+1.
REQ-011 In DONE, out_valid SHALL be 1 and out_state SHALL equal state_reg. Both SHALL stay stable until out_valid&&out_ready; the FSM then returns to IDLE on the next edge.
REQ-012 in_valid SHALL be ignored outside IDLE; no job is queued.
REQ-013 Inputs SHALL be canonical (< p). All modular sums SHALL produce canonical results, including wrap when operands sum to 2p or more.
REQ-014 The round counter SHALL be RC_ADDR_W bits and SHALL never exceed NUM_ROUNDS-1.

Reset
REQ-015 Asserting rst_n low, including mid-job, SHALL immediately force:
- FSM to IDLE.
- round, rc_addr, state_reg, out_state to 0.
- out_valid and busy to 0; in_ready to 1 after release.
- The in-flight job is discarded.

Configuration
REQ-016 With macro GRIFFIN_AFFINE_SCHED_ABORT_EN defined, an extra 1-bit input abort SHALL exist. abort high in FETCH, APPLY or DONE SHALL return the FSM to IDLE on the next edge. It SHALL suppress out_valid, clear round, and leave state_reg unchanged. abort in IDLE SHALL have no effect. Without the macro, the port and logic SHALL be absent.

Verification
REQ-017 NUM_ROUNDS=1, in_state=(1,2,3), rc(0)=(10,20,30) -> out_state=(17,28,39), out_valid first high at T+3.
REQ-018 NUM_ROUNDS=2, in_state=(1,2,3), all rc=0 -> after round 0 (7,8,9), final out_state=(31,32,33) at T+5.
REQ-019 in_state=(p-1,0,0), rc=0, NUM_ROUNDS=1 -> out_state=(p-2,p-1,p-1).
REQ-020 out_ready held low 10 cycles in DONE -> out_valid and out_state remain stable, in_ready stays 0; in_valid pulses are ignored.
REQ-021 rst_n pulsed low in APPLY of round 5 -> all outputs 0 immediately; after release in_ready=1 and a new job completes correctly.
REQ-022 (ABORT_EN) abort in FETCH of round 3 -> IDLE next cycle, no out_valid pulse.

Source files
------------

// File: rtl/griffin_affine_sched.sv
// -----------------------------------------------------------------------------
// griffin_affine_sched
//
// Sequences the affine layer of a Griffin-style permutation over GF(p).
// A job carries STATE_SIZE field elements. For each of NUM_ROUNDS rounds the
// scheduler fetches that round's constants from an external ROM (FETCH) and
// then applies, in a single cycle (APPLY),
//     state[i] <= state[i] + rc[i] + sum(state)   (all mod p).
// The finished state is held in DONE until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   job offered             in_ready   scheduler idle, can accept
//   in_state   initial state (packed, element i at [i])
//   rc_addr    ROM address = current round index
//   rc_data    ROM data, valid one cycle after rc_addr
//   out_valid  result available        out_ready  consumer accepts result
//   out_state  final state
//   busy       high whenever the FSM is not IDLE
//
// Optional feature (macro GRIFFIN_AFFINE_SCHED_ABORT_EN):
//   adds input 'abort'; when high outside IDLE the FSM returns to IDLE on the
//   next edge, dropping the job, clearing the round counter and suppressing
//   out_valid. state_reg keeps whatever value it had.
// -----------------------------------------------------------------------------
module griffin_affine_sched #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int                STATE_SIZE    = 3,
  parameter int                NUM_ROUNDS    = 14,
  parameter int                RC_ADDR_W     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]    in_state,
  output logic [RC_ADDR_W-1:0]                 rc_addr,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]    rc_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]    out_state,
  output logic                                 busy
`ifdef GRIFFIN_AFFINE_SCHED_ABORT_EN
  ,
  input  logic                                 abort
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, APPLY, DONE} fsm_t;

  localparam logic [RC_ADDR_W-1:0] LAST_ROUND = RC_ADDR_W'(NUM_ROUNDS - 1);

  fsm_t                               fsm;
  logic [RC_ADDR_W-1:0]               round;
  logic [STATE_SIZE-1:0][N_BITS-1:0]  state_reg;
  logic [STATE_SIZE-1:0][N_BITS-1:0]  next_state;
  logic [N_BITS-1:0]                  sum_all;
  logic                               abort_hit;

  // Both operands are canonical (< p), so a+b < 2p and one conditional
  // subtraction restores a canonical result. The extra carry bit matters:
  // p is above 2^253, so a+b can overflow N_BITS.
  function automatic logic [N_BITS-1:0] add_mod(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PRIME_MODULUS}) s = s - {1'b0, PRIME_MODULUS};
    return s[N_BITS-1:0];
  endfunction

  // NOTE: every variable assigned in always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    sum_all    = '0;
    next_state = '0;
    for (int i = 0; i < STATE_SIZE; i++) sum_all = add_mod(sum_all, state_reg[i]);
    for (int i = 0; i < STATE_SIZE; i++)
      next_state[i] = add_mod(add_mod(state_reg[i], rc_data[i]), sum_all);
  end

`ifdef GRIFFIN_AFFINE_SCHED_ABORT_EN
  assign abort_hit = abort && (fsm != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign rc_addr   = round;
  assign out_state = state_reg;

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of statement
  // order. state_reg is a wide datapath register but is still reset, because
  // out_state must read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      round     <= '0;
      state_reg <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (abort_hit) begin
      fsm       <= IDLE;
      round     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_reg <= in_state;
            round     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm       <= FETCH;
          end
        end
        // rc_addr already shows the round; the ROM answers during APPLY.
        FETCH: fsm <= APPLY;
        APPLY: begin
          state_reg <= next_state;
          if (round == LAST_ROUND) begin
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            round <= round + 1'b1;
            fsm   <= FETCH;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
